mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single 32-bit memory bus (address/data/datao/rw) between two requesters:
//  port 0 = cpu core, port 1 = program loader / debug port.
//  Per-port req/ack handshake; one transaction in flight; round-robin on conflict.
//  Registered, wait-state-aware memory strobe; sits between the cpu and external memory.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  WAIT_CYCLES 1   extra memory wait states (>=0); ACCESS lasts WAIT_CYCLES+1 cycles
// PORTS
//  clock        in   1   single clock, all state on posedge
//  reset        in   1   asynchronous, active-high reset
//  m0_req       in   1   port 0 request; held with m0_rw/addr/wdata until m0_ack
//  m0_rw        in   1   1=write, 0=read
//  m0_addr      in   AW  port 0 address
//  m0_wdata     in   DW  port 0 write data
//  m0_rdata     out  DW  port 0 read data; valid while m0_ack=1, held after
//  m0_ack       out  1   one-cycle completion pulse
//  m1_req/m1_rw/m1_addr/m1_wdata/m1_rdata/m1_ack   same as port 0, for port 1
//  mem_address  out  AW  memory address (latched)
//  mem_datao    out  DW  memory write data (latched)
//  mem_rw       out  1   1=write; forced 0 when mem_en=0
//  mem_en       out  1   memory strobe, high for whole ACCESS state
//  mem_data     in   DW  memory read data, sampled on last ACCESS cycle
//  busy         out  1   state != IDLE
//  grant        out  1   owner of current transaction (0/1); holds last owner when idle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, all outputs 0, wait counter 0,
//   last_grant=1 so port 0 wins the first tie.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: no req -> stay. Exactly one req -> that port. Both -> port != last_grant.
//   On grant: latch rw/addr/wdata into mem_* regs, set grant, cnt=WAIT_CYCLES, -> ACCESS.
//  ACCESS: mem_en=1, mem_rw=latched rw. cnt!=0 -> cnt-1, stay. cnt==0 -> if read, capture
//   mem_data into owner's rdata reg; -> DONE. Inputs from requesters ignored here.
//  DONE: owner's ack=1 for exactly this cycle, mem_en=0, mem_rw=0;
//   last_grant<=grant; -> IDLE.
//  Latency: req high in IDLE cycle T -> ack in cycle T+WAIT_CYCLES+2.
//   Min turnaround: 1 IDLE cycle between transactions.
//  Requester must drop req on the edge ending its ack cycle. A req still high in the next
//   IDLE cycle is a new request.
//  req dropped mid-transaction: access still completes, ack still pulses once, no retry.
//  Writes: rdata regs unchanged. Non-owner rdata/ack never change.
//  mem_address/mem_datao hold their last latched value outside ACCESS.
//  Counter width clog2(WAIT_CYCLES+1), min 1 bit; WAIT_CYCLES=0 gives a 1-cycle ACCESS.
//  Fairness: with both reqs held continuously, grants strictly alternate 0,1,0,1...
// TESTING (WAIT_CYCLES=1 unless noted)
//  1 reset; m0 read 0x10, mem_data=DEADBEEF -> mem_en cyc1-2, m0_ack cyc3, m0_rdata=DEADBEEF
//  2 m0,m1 req same cycle after reset -> m0 acked first, m1 next; both held -> 0,1,0,1 grants
//  3 m1 write 0x20/12345678 -> mem_rw=1, addr 0x20, datao 12345678 for 2 cycles;
//     m1_ack once; m1_rdata unchanged
//  4 reset pulse mid-ACCESS -> all outputs 0 immediately, no ack; m0 re-req served normally
//  5 m0 drops req after 1 ACCESS cycle -> access finishes, single m0_ack, no second mem_en
//  6 WAIT_CYCLES=0 and 3 -> ack at T+2 / T+5; mem_en width 1 / 4 cycles

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: req/ack handshake per port, one transaction in flight,
// round-robin on conflict, registered wait-state-aware memory strobe.
module mem_bus_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_rw,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_rw,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_datao,
    output logic          mem_rw,
    output logic          mem_en,
    input  logic [DW-1:0] mem_data,
    output logic          busy,
    output logic          grant
);

    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          rw_q;
    logic          last_grant;
    logic          take;
    logic          pick;

    // On a tie the port that was not served last wins; otherwise whoever is asking.
    assign pick = (m0_req && m1_req) ? ~last_grant : m1_req;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    take      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_address <= '0;
            mem_datao   <= '0;
            rw_q        <= 1'b0;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
        end else begin
            if (take) begin
                mem_address <= pick ? m1_addr  : m0_addr;
                mem_datao   <= pick ? m1_wdata : m0_wdata;
                rw_q        <= pick ? m1_rw    : m0_rw;
                grant       <= pick;
                cnt         <= CW'(WAIT_CYCLES);
            end
            if (state == ACCESS) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (!rw_q) begin
                    if (grant) m1_rdata <= mem_data;
                    else       m0_rdata <= mem_data;
                end
            end
            if (state == DONE) last_grant <= grant;
        end
    end

    assign mem_en = (state == ACCESS);
    assign mem_rw = mem_en & rw_q;
    assign busy   = (state != IDLE);
    assign m0_ack = (state == DONE) && !grant;
    assign m1_ack = (state == DONE) &&  grant;

endmodule
